// File: rtl/bht_scheduler.sv
// bht_scheduler: arbitrates a single-port BHT between fetch lookups and queued ROB counter updates.
`timescale 1ns/1ps
module bht_scheduler #(
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             if_req_valid,
  input  logic [IDX_W-1:0] if_req_idx,
  output logic             if_req_ready,
  output logic             if_rsp_valid,
  output logic             if_rsp_taken,
  input  logic             flush,
  input  logic             rob_upd_valid,
  input  logic [IDX_W-1:0] rob_upd_idx,
  input  logic             rob_upd_taken,
  output logic             rob_upd_ready,
  output logic             bht_en,
  output logic             bht_we,
  output logic [IDX_W-1:0] bht_addr,
  output logic [1:0]       bht_wdata,
  input  logic [1:0]       bht_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  typedef enum logic {IDLE, UPD_WR} state_t;
  state_t           r_state;
  logic [IDX_W:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_cnt;
  logic [SW-1:0]    r_starve;
  logic             r_rsp_valid;
  logic             w_full, w_nempty, w_grant, w_ready, w_accept, w_push, w_wr, w_head_tk;
  logic [IDX_W-1:0] w_head_idx;
  logic [1:0]       w_inc, w_dec;
  assign {w_head_idx, w_head_tk} = r_mem[r_rptr];
  assign w_full   = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign w_nempty = r_cnt != '0;
  assign w_wr     = rdy && r_state == UPD_WR;
  assign w_grant  = rdy && r_state == IDLE && w_nempty &&
                    (w_full || r_starve == SW'(STARVE_MAX) || !if_req_valid);
  // rst gating keeps every handshake and port output low while reset is held
  assign w_ready  = rst && rdy && r_state == IDLE && !w_grant;
  assign w_accept = if_req_valid && w_ready;
  assign w_push   = rob_upd_valid && rob_upd_ready;
  assign w_inc    = bht_rdata == 2'd3 ? 2'd3 : bht_rdata + 2'd1;
  assign w_dec    = bht_rdata == 2'd0 ? 2'd0 : bht_rdata - 2'd1;
  assign if_req_ready  = w_ready;
  assign rob_upd_ready = rst && rdy && !w_full;
  assign if_rsp_valid  = r_rsp_valid;
  assign if_rsp_taken  = r_rsp_valid && bht_rdata[1];
  assign bht_en    = w_accept || w_grant || w_wr;
  assign bht_we    = w_wr;
  assign bht_addr  = (w_grant || w_wr) ? w_head_idx : w_accept ? if_req_idx : '0;
  assign bht_wdata = w_wr ? (w_head_tk ? w_inc : w_dec) : 2'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_rsp_valid <= 1'b0;
    end else if (rdy) begin
      r_state     <= w_grant ? UPD_WR : IDLE;
      r_rsp_valid <= w_accept && !flush;
      r_wptr      <= w_push ? r_wptr + PW'(1) : r_wptr;
      r_rptr      <= w_wr ? r_rptr + PW'(1) : r_rptr;
      r_cnt       <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_wr);
      r_starve    <= (w_grant || !w_nempty) ? '0 :
                     (w_accept && r_starve != SW'(STARVE_MAX)) ? r_starve + SW'(1) : r_starve;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {rob_upd_idx, rob_upd_taken};
  end
endmodule

// File: tb/tb_bht_scheduler.sv
// tb_bht_scheduler: random and directed stimulus checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_bht_scheduler;
  logic       clk = 0, rst = 0, rdy = 0, if_req_valid = 0, flush = 0, rob_upd_valid = 0, rob_upd_taken = 0;
  logic [7:0] if_req_idx = 0, rob_upd_idx = 0;
  logic       if_req_ready, if_rsp_valid, if_rsp_taken, rob_upd_ready, bht_en, bht_we;
  logic [7:0] bht_addr;
  logic [1:0] bht_wdata, bht_rdata;
  logic [1:0] mem [256];
  logic [1:0] ref_ctr [256];
  int checks = 0, failures = 0;
  typedef struct {logic [7:0] idx; logic tk;} upd_t;
  upd_t q[$];
  bit pend, rsp_v, rsp_t, obs_ready;
  int starve;
  always #5 clk = ~clk;
  bht_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_valid(if_req_valid), .if_req_idx(if_req_idx), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_taken(if_rsp_taken), .flush(flush),
    .rob_upd_valid(rob_upd_valid), .rob_upd_idx(rob_upd_idx), .rob_upd_taken(rob_upd_taken),
    .rob_upd_ready(rob_upd_ready), .bht_en(bht_en), .bht_we(bht_we), .bht_addr(bht_addr),
    .bht_wdata(bht_wdata), .bht_rdata(bht_rdata)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    int n = t ? int'(c) + 1 : int'(c) - 1;
    return 2'(n > 3 ? 3 : n < 0 ? 0 : n);
  endfunction
  task automatic cyc(input bit r, input bit v, input logic [7:0] idx, input bit fl,
                     input bit uv, input logic [7:0] uidx, input bit ut);
    bit full, ne, grant, rdyo, acc, upr, wr, e, w;
    logic [7:0] a;
    logic [1:0] d;
    @(negedge clk);
    rdy = r; if_req_valid = v; if_req_idx = idx; flush = fl;
    rob_upd_valid = uv; rob_upd_idx = uidx; rob_upd_taken = ut;
    #1;
    full  = q.size() == 4;
    ne    = q.size() != 0;
    grant = r && !pend && ne && (full || starve == 3 || !v);
    rdyo  = r && !pend && !grant;
    acc   = v && rdyo;
    upr   = r && !full;
    wr    = r && pend;
    obs_ready = if_req_ready;
    chk("if_req_ready", if_req_ready, rdyo);
    chk("rob_upd_ready", rob_upd_ready, upr);
    chk("bht_en", bht_en, acc || grant || wr);
    chk("bht_we", bht_we, wr);
    if (grant || wr) chk("bht_addr_upd", bht_addr, q[0].idx);
    else if (acc) chk("bht_addr_if", bht_addr, idx);
    if (wr) chk("bht_wdata", bht_wdata, sat(ref_ctr[q[0].idx], q[0].tk));
    chk("if_rsp_valid", if_rsp_valid, rsp_v);
    if (rsp_v) chk("if_rsp_taken", if_rsp_taken, rsp_t);
    e = bht_en; w = bht_we; a = bht_addr; d = bht_wdata;
    @(posedge clk);
    if (e) begin
      if (w) mem[a] = d;
      else bht_rdata = mem[a];
    end
    if (r) begin
      if (acc) rsp_t = ref_ctr[idx][1];
      rsp_v = acc && !fl;
      if (grant || !ne) starve = 0;
      else if (acc && starve < 3) starve++;
      if (wr) begin
        ref_ctr[q[0].idx] = sat(ref_ctr[q[0].idx], q[0].tk);
        void'(q.pop_front());
        pend = 0;
      end
      if (grant) pend = 1;
      if (uv && upr) q.push_back('{idx: uidx, tk: ut});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rdy = 1; if_req_valid = 1; rob_upd_valid = 1;
    #2 rst = 0;
    #1;
    chk("rst_if_req_ready", if_req_ready, 0);
    chk("rst_rob_upd_ready", rob_upd_ready, 0);
    chk("rst_rsp_valid", if_rsp_valid, 0);
    chk("rst_rsp_taken", if_rsp_taken, 0);
    chk("rst_bht_en", bht_en, 0);
    chk("rst_bht_we", bht_we, 0);
    chk("rst_bht_addr", bht_addr, 0);
    chk("rst_bht_wdata", bht_wdata, 0);
    q.delete(); pend = 0; starve = 0; rsp_v = 0;
    @(negedge clk);
    rdy = 0; if_req_valid = 0; rob_upd_valid = 0; flush = 0;
    rst = 1;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 2'($urandom_range(0, 3));
      ref_ctr[i] = mem[i];
    end
    mem[5] = 2'b10; ref_ctr[5] = 2'b10;
    mem[7] = 2'b11; ref_ctr[7] = 2'b11;
    do_reset();
    cyc(1, 1, 5, 0, 0, 0, 0);
    #1 chk("lookup5_valid", if_rsp_valid, 1);
    chk("lookup5_taken", if_rsp_taken, 1);
    idle(1);
    cyc(1, 0, 0, 0, 1, 7, 1);
    idle(3);
    chk("ctr7_saturate_up", mem[7], 3);
    mem[7] = 2'b00; ref_ctr[7] = 2'b00;
    cyc(1, 0, 0, 0, 1, 7, 0);
    idle(3);
    chk("ctr7_saturate_down", mem[7], 0);
    cyc(1, 1, 1, 0, 1, 9, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 8'(i + 2), 0, 0, 0, 0);
      n += int'(obs_ready);
    end
    chk("starve_accepts", n, 3);
    cyc(1, 1, 3, 0, 0, 0, 0);
    chk("starve_ready_back", obs_ready, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 8'(i), 0, i < 4, 8'(10 + i), i[0]);
    idle(12);
    cyc(1, 1, 6, 1, 1, 4, 0);
    #1 chk("flush_drops_rsp", if_rsp_valid, 0);
    idle(3);
    cyc(1, 0, 0, 0, 1, 12, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(2);
    cyc(1, 0, 0, 0, 1, 13, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 0, 1, 3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("stalled_write", mem[13], ref_ctr[13]);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if ($urandom_range(0, 499) == 0) do_reset();
      r = $urandom_range(0, 7) != 0;
      cyc(r, $urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), r && $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) < 4, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle(16);
    for (int i = 0; i < 16; i++) chk($sformatf("final_ctr%0d", i), mem[i], ref_ctr[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bht_scheduler.md
BHT_SCHEDULER -- requirements
Module: bht_scheduler

Interface
REQ-001 Parameter IDX_W, default 8, sets the BHT index width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the ROB-update FIFO depth; it is a power of 2 and at least 2.
REQ-003 Parameter STARVE_MAX, default 3, is the maximum number of consecutive IF grants while an update is pending.
REQ-004 clk  in  1  sole clock; all state changes on the posedge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 rdy  in  1  global enable; when low, the block freezes.
REQ-007 if_req_valid  in  1  fetch asks for a prediction.
REQ-008 if_req_idx  in  IDX_W  BHT index of the fetched branch.
REQ-009 if_req_ready  out  1  lookup accepted this cycle (accept = valid && ready).
REQ-010 if_rsp_valid  out  1  prediction valid; asserted 1 cycle after accept.
REQ-011 if_rsp_taken  out  1  predicted taken, equal to bit 1 of the read counter.
REQ-012 flush  in  1  pipeline flush from the ROB.
REQ-013 rob_upd_valid  in  1  resolved branch feedback.
REQ-014 rob_upd_idx  in  IDX_W  index of the resolved branch.
REQ-015 rob_upd_taken  in  1  actual outcome of the resolved branch.
REQ-016 rob_upd_ready  out  1  FIFO not full.
REQ-017 bht_en  out  1  BHT port access this cycle.
REQ-018 bht_we  out  1  write (1) or read (0).
REQ-019 bht_addr  out  IDX_W  BHT port address.
REQ-020 bht_wdata  out  2  counter value written.
REQ-021 bht_rdata  in  2  synchronous read data, valid 1 cycle after a read; held by the BHT while bht_en=0.

Function
REQ-022 The single BHT port SHALL perform at most one access per cycle, shared between IF lookups and update read-modify-writes.
REQ-023 The FSM SHALL have two states:
- IDLE: the port is free for a lookup or an update read.
- UPD_WR: the update write is pending.
REQ-024 upd_grant SHALL = rdy && state==IDLE && fifo_nonempty && (fifo_full || starve_cnt==STARVE_MAX || !if_req_valid).
REQ-025 if_req_ready SHALL = rdy && state==IDLE && !upd_grant.
REQ-026 On accept, the block SHALL drive bht_en=1, bht_we=0, bht_addr=if_req_idx.
REQ-027 On the next enabled cycle, if_rsp_valid=1 and if_rsp_taken=bht_rdata[1]; if_rsp_valid SHALL otherwise be 0.
REQ-028 Back-to-back lookups SHALL sustain 1 per cycle.
REQ-029 On upd_grant, the block SHALL drive bht_en=1, bht_we=0, bht_addr=FIFO head idx, and go to UPD_WR.
REQ-030 In UPD_WR with rdy=1, the block SHALL:
- drive bht_en=1, bht_we=1, bht_addr=head idx;
- drive bht_wdata = taken ? min(bht_rdata+1,3) : max(bht_rdata-1,0) (2-bit saturating);
- pop the FIFO and return to IDLE.
REQ-031 A given update therefore occupies the port for exactly 2 enabled cycles; if_req_ready SHALL be 0 in both.
REQ-032 starve_cnt (width for 0..STARVE_MAX) SHALL:
- increment on an accept while the FIFO is non-empty, saturating at STARVE_MAX;
- clear on upd_grant and whenever the FIFO is empty.
REQ-033 The FIFO SHALL push {idx,taken} when rob_upd_valid && rob_upd_ready && rdy.
REQ-034 rob_upd_ready SHALL = rdy && !fifo_full; there is no push while full, even in a pop cycle.
REQ-035 A push and pop in the same cycle SHALL leave the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-036 Updates SHALL apply in FIFO order; writes to an index SHALL never be reordered.
REQ-037 A lookup of an index whose update is still in the FIFO SHALL return the old counter; no forwarding is performed.
REQ-038 flush SHALL force if_rsp_valid=0 in the next cycle, dropping any in-flight response.
REQ-039 flush SHALL NOT affect FIFO contents, the FSM state or starve_cnt; committed feedback is never discarded.
REQ-040 With rdy=0, the block SHALL hold all registers, drive bht_en=0, if_req_ready=0 and rob_upd_ready=0, and keep if_rsp_valid at its current value.
REQ-041 An UPD_WR stalled by rdy=0 SHALL complete on the first cycle with rdy=1, using the held bht_rdata.

Reset
REQ-042 While rst=0, the block SHALL set:
- state=IDLE, FIFO empty, starve_cnt=0;
- if_rsp_valid=0, if_rsp_taken=0;
- bht_en=0, bht_we=0, bht_addr=0, bht_wdata=0.
REQ-043 rst SHALL take effect immediately regardless of clk; an update interrupted mid-RMW is lost, with no partial write.
REQ-044 BHT array initialisation SHALL be outside this block.

Verification
REQ-045 Lookup: counter[5]=2'b10; accept idx 5 -> next cycle if_rsp_valid=1, if_rsp_taken=1.
REQ-046 Update: counter[7]=2'b11, push {7,taken=1} with IF idle -> read at 7, then write 2'b11 (saturated); counter[7]=2'b00 with taken=0 -> writes 2'b00.
REQ-047 Starvation (STARVE_MAX=3): FIFO holds 1 entry and if_req_valid is held high -> exactly 3 lookups accepted, then if_req_ready=0 for 2 cycles while the update RMW runs.
REQ-048 Full FIFO: 4 pushes with IF busy -> rob_upd_ready=0; the update is granted over IF the next cycle; after the write completes, rob_upd_ready=1.
REQ-049 Flush and reset:
- flush in the cycle after an accept -> if_rsp_valid=0; FIFO count unchanged.
- rst low mid-UPD_WR -> all outputs 0 and FIFO empty at once.
REQ-050 rdy low during UPD_WR for 3 cycles -> bht_en=0 for those cycles, then a single correct write once rdy returns.
